pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register for the SELEN CPU. It replaces the hand-written per-stage registers with one generic block that has:
- payload and control fields of configurable width;
- a valid/ready handshake;
- synchronous flush;
- automatic bubble masking of control bits;
- an optional 2-entry skid buffer that breaks the combinational ready path.

It sits between any two pipeline stages (decode→execute, execute→memory, memory→writeback) and also exposes a stall-cycle counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : generic valid/ready pipeline register with flush, control
//                  bubble masking, stall counter and optional 2-entry skid.
// Revision       : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              main_valid, accept, deliver;
  logic              main_load, main_from_skid, skid_load;

  assign main_valid = (state_q != S_EMPTY);
  assign accept     = in_valid && in_ready;
  assign deliver    = main_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: depends only on whether the skid slot is occupied.
      assign in_ready = (state_q != S_TWO);

      always_ff @(posedge clk) begin
        if (rst) begin
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
        end else if (flush) begin
          skid_ctrl_q <= '0;
        end else if (skid_load) begin
          skid_data_q <= in_data;
          skid_ctrl_q <= in_ctrl;
        end
      end
    end else begin : g_noskid
      assign in_ready    = !main_valid || out_ready;
      assign skid_data_q = '0;
      assign skid_ctrl_q = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && deliver) begin
          main_load = 1'b1;
        end else if (accept && (SKID != 0)) begin
          skid_load = 1'b1;
          state_d   = S_TWO;
        end else if (deliver) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (deliver) begin
          main_from_skid = 1'b1;
          state_d        = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush discards everything held and any beat offered this cycle.
    if (flush) begin
      state_d        = S_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (flush) begin
      main_ctrl_q <= '0;
    end else if (main_load) begin
      main_data_q <= in_data;
      main_ctrl_q <= in_ctrl;
    end else if (main_from_skid) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_valid ? main_ctrl_q : '0;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// tb_pipe_stage_reg : directed vectors on a SKID=0 instance (u0) and a
// SKID=1, CNT_W=4 instance (u1), checked against a FIFO-level reference model.
module tb_pipe_stage_reg;
  localparam int DW = 96;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    iv, ordy, fl, ov, irdy;
  logic [DW-1:0] idat [2];
  logic [CW-1:0] ictl [2];
  logic [DW-1:0] od   [2];
  logic [CW-1:0] oc   [2];
  logic [1:0]    occ  [2];
  logic [15:0]   sc0;
  logic [3:0]    sc1;
  int            vecs = 0;
  int            miss = 0;
  bit            started = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(idat[0]), .in_ctrl(ictl[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ctrl(oc[0]),
    .occupancy(occ[0]), .stall_cnt(sc0)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(idat[1]), .in_ctrl(ictl[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ctrl(oc[1]),
    .occupancy(occ[1]), .stall_cnt(sc1)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered queue of at most 1 (u0) or 2 (u1) beats.
  logic [DW-1:0] md    [2][2];
  logic [CW-1:0] mc    [2][2];
  logic [DW-1:0] mlast [2];
  int            mn    [2];
  int            mst   [2];
  int            smax  [2];
  bit            mv, mir, dlv, acc;

  initial begin
    smax[0] = 65535;
    smax[1] = 15;
  end

  function automatic bit model_ready(input int d);
    return (d == 1) ? (mn[d] < 2) : (mn[d] == 0 || ordy[d]);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mn[d]    = 0;
        mst[d]   = 0;
        mlast[d] = '0;
      end else begin
        mv  = (mn[d] > 0);
        mir = model_ready(d);
        dlv = mv && ordy[d];
        acc = iv[d] && mir && !fl[d];
        if (mv && !ordy[d] && mst[d] < smax[d]) mst[d] = mst[d] + 1;
        if (fl[d]) begin
          mn[d] = 0;
        end else begin
          if (dlv) begin
            md[d][0] = md[d][1];
            mc[d][0] = mc[d][1];
            mn[d]    = mn[d] - 1;
          end
          if (acc) begin
            md[d][mn[d]] = idat[d];
            mc[d][mn[d]] = ictl[d];
            mn[d]        = mn[d] + 1;
          end
        end
        if (mn[d] > 0) mlast[d] = md[d][0];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("u%0d out_valid", d), DW'(ov[d]), DW'(mn[d] > 0));
        chk($sformatf("u%0d out_ctrl", d), DW'(oc[d]), (mn[d] > 0) ? DW'(mc[d][0]) : '0);
        chk($sformatf("u%0d out_data", d), od[d], mlast[d]);
        chk($sformatf("u%0d occupancy", d), DW'(occ[d]), DW'(mn[d]));
        chk($sformatf("u%0d in_ready", d), DW'(irdy[d]), DW'(model_ready(d)));
        chk($sformatf("u%0d stall_cnt", d), (d == 0) ? DW'(sc0) : DW'(sc1), DW'(mst[d]));
      end
    end
  end

  initial begin
    rst     = 1'b1;
    iv      = 2'b11;
    ordy    = 2'b00;
    fl      = 2'b00;
    idat[0] = DW'(32'h55);
    idat[1] = DW'(32'hAA);
    ictl[0] = '1;
    ictl[1] = '1;
    tick();
    started = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset out_valid", DW'(ov[d]), '0);
      chk("reset out_ctrl", DW'(oc[d]), '0);
      chk("reset out_data", od[d], '0);
      chk("reset occupancy", DW'(occ[d]), '0);
    end
    chk("reset stall0", DW'(sc0), '0);
    chk("reset stall1", DW'(sc1), '0);
    rst = 1'b0;
    iv  = 2'b00;
    tick();
    chk("ready after reset", DW'(irdy), DW'(2'b11));

    // Streaming through the skid instance at full rate.
    ordy[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      iv[1]   = 1'b1;
      idat[1] = DW'(k);
      ictl[1] = CW'(k);
      tick();
      chk("stream data", od[1], DW'(k));
      chk("stream occ", DW'(occ[1]), DW'(1));
    end
    iv[1] = 1'b0;
    tick();
    chk("stream drained", DW'(ov[1]), '0);

    // Backpressure: A, B, C with downstream stalled from A's output cycle.
    iv[1] = 1'b1; idat[1] = DW'(32'hA0A0); ictl[1] = 16'h000A;
    tick();
    chk("bp A out", od[1], DW'(32'hA0A0));
    ordy[1] = 1'b0; idat[1] = DW'(32'hB0B0); ictl[1] = 16'h000B;
    tick();
    chk("bp occ2", DW'(occ[1]), DW'(2));
    chk("bp ready low", DW'(irdy[1]), '0);
    idat[1] = DW'(32'hC0C0); ictl[1] = 16'h000C;
    tick();
    tick();
    chk("bp head A", od[1], DW'(32'hA0A0));
    chk("bp stall3", DW'(sc1), DW'(3));
    ordy[1] = 1'b1;
    tick();
    chk("bp B out", od[1], DW'(32'hB0B0));
    chk("bp ready back", DW'(irdy[1]), DW'(1));
    tick();
    chk("bp C out", od[1], DW'(32'hC0C0));
    chk("bp C ctrl", DW'(oc[1]), DW'(16'h000C));
    iv[1] = 1'b0;
    tick();
    chk("bp drained", DW'(ov[1]), '0);
    chk("bp stall total", DW'(sc1), DW'(3));

    // SKID=0: in_ready tracks out_ready combinationally while main is full.
    iv[0] = 1'b1; ordy[0] = 1'b1; idat[0] = DW'(32'h1111); ictl[0] = 16'h0011;
    tick();
    ordy[0] = 1'b0; idat[0] = DW'(32'h2222); ictl[0] = 16'h0022;
    #2 chk("pt ready low", DW'(irdy[0]), '0);
    tick();
    chk("pt hold P1", od[0], DW'(32'h1111));
    ordy[0] = 1'b1;
    #2 chk("pt ready high", DW'(irdy[0]), DW'(1));
    tick();
    chk("pt P2", od[0], DW'(32'h2222));
    ordy[0] = 1'b0; idat[0] = DW'(32'h3333); ictl[0] = 16'h0033;
    #2 chk("pt ready low2", DW'(irdy[0]), '0);
    tick();
    ordy[0] = 1'b1;
    #2 chk("pt ready high2", DW'(irdy[0]), DW'(1));
    tick();
    chk("pt P3", od[0], DW'(32'h3333));
    iv[0] = 1'b0;
    tick();
    chk("pt drained", DW'(ov[0]), '0);
    chk("pt stall", DW'(sc0), DW'(2));

    // Flush with both entries full and beat D offered.
    iv[1] = 1'b1; ordy[1] = 1'b0; idat[1] = DW'(32'hE0E0); ictl[1] = 16'h000E;
    tick();
    idat[1] = DW'(32'hF0F0); ictl[1] = 16'h000F;
    tick();
    chk("fl occ2", DW'(occ[1]), DW'(2));
    chk("fl stall before", DW'(sc1), DW'(4));
    idat[1] = DW'(32'hD0D0); ictl[1] = 16'h000D; fl[1] = 1'b1; ordy[1] = 1'b1;
    tick();
    chk("fl valid", DW'(ov[1]), '0);
    chk("fl ctrl", DW'(oc[1]), '0);
    chk("fl occ", DW'(occ[1]), '0);
    chk("fl stall kept", DW'(sc1), DW'(4));
    fl[1] = 1'b0; iv[1] = 1'b0;
    tick();
    tick();
    chk("fl D never out", DW'(ov[1]), '0);
    iv[1] = 1'b1; idat[1] = DW'(32'h6060); ictl[1] = 16'h0006; fl[1] = 1'b1;
    tick();
    chk("fl beats ready", DW'(ov[1]), '0);
    fl[1] = 1'b0; iv[1] = 1'b0;
    tick();
    chk("fl G never out", DW'(ov[1]), '0);

    // Saturation of the 4-bit stall counter.
    iv[1] = 1'b1; ordy[1] = 1'b0; idat[1] = DW'(32'h5A5A); ictl[1] = 16'h0055;
    tick();
    iv[1] = 1'b0;
    repeat (20) tick();
    chk("sat 15", DW'(sc1), DW'(15));
    repeat (2) tick();
    chk("sat hold", DW'(sc1), DW'(15));
    chk("sat head", od[1], DW'(32'h5A5A));
    ordy[1] = 1'b1;
    tick();
    chk("sat drained", DW'(ov[1]), '0);
    tick();

    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
`default_nettype wire
